shake128_xof_ctrl: RTL and testbench



---
 rtl/shake128_xof_ctrl_if.sv | 39 +++
 rtl/shake128_xof_ctrl.sv | 102 ++++++++++
 tb/tb_shake128_xof_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/shake128_xof_ctrl_if.sv
// shake128_xof_ctrl_if: command, message, output-stream and core-side signals of shake128_xof_ctrl
interface shake128_xof_ctrl_if #(parameter int LEN_W = 16);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [LEN_W-1:0] i_cmd_in_words;
    logic [LEN_W-1:0] i_cmd_out_words;
    logic [63:0]      i_msg_data;
    logic             i_msg_valid;
    logic             o_msg_ready;
    logic [63:0]      o_out_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_out_last;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic             o_core_rst_n;
    logic [63:0]      o_core_data;
    logic             o_core_valid;
    logic             o_core_last;
    logic             i_core_ready;
    logic [63:0]      i_core_data;
    logic             i_core_valid;
    logic             o_core_ack;

    modport slave (
        input  i_cmd_valid, i_cmd_in_words, i_cmd_out_words, i_msg_data, i_msg_valid,
               i_out_ready, i_core_ready, i_core_data, i_core_valid,
        output o_cmd_ready, o_msg_ready, o_out_data, o_out_valid, o_out_last, o_busy,
               o_done, o_err, o_core_rst_n, o_core_data, o_core_valid, o_core_last, o_core_ack
    );

    modport master (
        output i_cmd_valid, i_cmd_in_words, i_cmd_out_words, i_msg_data, i_msg_valid,
               i_out_ready, i_core_ready, i_core_data, i_core_valid,
        input  o_cmd_ready, o_msg_ready, o_out_data, o_out_valid, o_out_last, o_busy,
               o_done, o_err, o_core_rst_n, o_core_data, o_core_valid, o_core_last, o_core_ack
    );
endinterface

// File: rtl/shake128_xof_ctrl.sv
// shake128_xof_ctrl: job sequencer for shake128_top (reset core, absorb message, drain squeeze words).
// Define SHAKE128_CTRL_BYTESWAP_EN to byte-reverse message and output words (test-vector byte order).
module shake128_xof_ctrl #(
    parameter int LEN_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input logic                i_clk,
    input logic                i_rst,
    shake128_xof_ctrl_if.slave bus
);
    localparam int CW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CORE_RST, ABSORB, WAIT_OUT, DELIVER, ACK, GAP} state_t;

    function automatic logic [63:0] swap(input logic [63:0] x);
        logic [63:0] r;
`ifdef SHAKE128_CTRL_BYTESWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56-8*i +: 8];
`else
        r = x;
`endif
        return r;
    endfunction

    state_t           state, next;
    logic [LEN_W-1:0] in_rem, out_rem;
    logic [CW-1:0]    rst_cnt;
    logic [63:0]      out_data;
    logic             out_last, done, err;
    logic             cmd_hs, zero_len, msg_hs, out_hs, rst_done;

    assign cmd_hs   = bus.i_cmd_valid & (state == IDLE);
    assign zero_len = (bus.i_cmd_in_words == '0) | (bus.i_cmd_out_words == '0);
    assign msg_hs   = (state == ABSORB) & bus.i_msg_valid & bus.i_core_ready;
    assign out_hs   = (state == DELIVER) & bus.i_out_ready;
    assign rst_done = rst_cnt == CW'(RST_CYCLES - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = (cmd_hs & ~zero_len) ? CORE_RST : IDLE;
            CORE_RST: next = rst_done ? ABSORB : CORE_RST;
            ABSORB:   next = (msg_hs & (in_rem == LEN_W'(1))) ? WAIT_OUT : ABSORB;
            WAIT_OUT: next = bus.i_core_valid ? DELIVER : WAIT_OUT;
            DELIVER:  next = out_hs ? ((out_rem == LEN_W'(1)) ? IDLE : ACK) : DELIVER;
            ACK:      next = GAP;
            GAP:      next = WAIT_OUT;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_rem   <= '0;
            out_rem  <= '0;
            rst_cnt  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= out_hs & (out_rem == LEN_W'(1));
            err  <= cmd_hs & zero_len;
            if (cmd_hs) begin
                in_rem  <= bus.i_cmd_in_words;
                out_rem <= bus.i_cmd_out_words;
                rst_cnt <= '0;
            end
            if (state == CORE_RST) rst_cnt <= rst_cnt + 1'b1;
            if (msg_hs) in_rem <= in_rem - 1'b1;
            if ((state == WAIT_OUT) & bus.i_core_valid) begin
                out_data <= swap(bus.i_core_data);
                out_last <= out_rem == LEN_W'(1);
            end
            if (out_hs) begin
                out_rem  <= out_rem - 1'b1;
                out_last <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.o_cmd_ready  = state == IDLE;
        bus.o_busy       = state != IDLE;
        bus.o_msg_ready  = (state == ABSORB) & bus.i_core_ready;
        bus.o_core_data  = swap(bus.i_msg_data);
        bus.o_core_valid = msg_hs;
        bus.o_core_last  = msg_hs & (in_rem == LEN_W'(1));
        bus.o_core_rst_n = ~i_rst & (state != CORE_RST);
        bus.o_out_valid  = state == DELIVER;
        bus.o_out_data   = out_data;
        bus.o_out_last   = out_last;
        bus.o_core_ack   = state == ACK;
        bus.o_done       = done;
        bus.o_err        = err;
    end
endmodule

// File: tb/tb_shake128_xof_ctrl.sv
// tb_shake128_xof_ctrl: directed vectors against a behavioural stand-in for shake128_top.
module tb_shake128_xof_ctrl;
    localparam int RC = 2;
    localparam logic [63:0] MSG0 = 64'h0000000078563412;
    localparam logic [63:0] TVO [4] = '{64'h57affc13ef3e6ff5, 64'h11f8914a0bbbc3b3,
                                        64'hcb44176616a8ce51, 64'h11c4b77120263e95};

    typedef struct {
        int          in_w;
        int          out_w;
        logic [63:0] m0, m1, m2;
        int          stall;
        logic        tog;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shake128_xof_ctrl_if #(.LEN_W(16)) bus();
    shake128_xof_ctrl #(.LEN_W(16), .RST_CYCLES(RC)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int tests = 0, fails = 0;
    int n_ack = 0, n_done = 0, n_rstn = 0;

    function automatic logic [63:0] bsw(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56-8*i +: 8];
        return r;
    endfunction

    // drv: test-vector word -> DUT message input; outx: core-native word -> DUT output
    function automatic logic [63:0] drv(input logic [63:0] m);
`ifdef SHAKE128_CTRL_BYTESWAP_EN
        return m;
`else
        return bsw(m);
`endif
    endfunction

    function automatic logic [63:0] outx(input logic [63:0] n);
`ifdef SHAKE128_CTRL_BYTESWAP_EN
        return bsw(n);
`else
        return n;
`endif
    endfunction

    // Stand-in core: xors absorbed words, squeezes a table perturbed by the message
    logic [63:0] cacc = '0;
    int          cidx = 0, cdly = 0;
    logic        csq = 1'b0, creg = 1'b1, cr_tog = 1'b0;
    always @(posedge clk) begin
        creg <= cr_tog ? ~creg : 1'b1;
        if (!bus.o_core_rst_n) begin
            cacc <= '0; cidx <= 0; csq <= 1'b0; cdly <= 0;
        end else begin
            if (bus.o_core_valid && bus.i_core_ready) begin
                cacc <= cacc ^ bus.o_core_data;
                if (bus.o_core_last) cdly <= 3;
            end
            if (cdly > 0) begin
                cdly <= cdly - 1;
                if (cdly == 1) csq <= 1'b1;
            end
            if (bus.o_core_ack) begin
                cidx <= cidx + 1;
                csq  <= 1'b0;
                cdly <= 2;
            end
        end
    end
    assign bus.i_core_ready = creg;
    assign bus.i_core_valid = csq;
    assign bus.i_core_data  = bsw(TVO[cidx & 3]) ^ cacc ^ MSG0 ^ 64'(cidx >> 2);

    always @(posedge clk) begin
        n_ack  <= n_ack + int'(bus.o_core_ack);
        n_done <= n_done + int'(bus.o_done);
        n_rstn <= n_rstn + int'(!bus.o_core_rst_n && !rst);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_cmd(input int in_w, input int out_w);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_in_words = 16'(in_w);
        bus.i_cmd_out_words = 16'(out_w);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] m, input logic last);
        int t = 0;
        bus.i_msg_valid = 1'b1;
        bus.i_msg_data = drv(m);
        #1;
        while (!bus.o_msg_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("msg_wait", 64'(t < 100), 1);
        chk("core_data", bus.o_core_data, bsw(m));
        chk("core_last", bus.o_core_last, last);
        @(negedge clk);
        bus.i_msg_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int a0, d0, r0, a1, t;
        logic [63:0] acc, exp, hd;
        logic [63:0] m [3];
        logic ok;
        m = '{v.m0, v.m1, v.m2};
        acc = '0;
        cr_tog = v.tog;
        @(negedge clk);
        a0 = n_ack; d0 = n_done; r0 = n_rstn;
        chk("cmd_ready", bus.o_cmd_ready, 1);
        send_cmd(v.in_w, v.out_w);
        for (int k = 0; k < v.in_w; k++) begin
            acc ^= bsw(m[k]);
            send_msg(m[k], k == v.in_w - 1);
        end
        for (int i = 0; i < v.out_w; i++) begin
            exp = outx(bsw(TVO[i & 3]) ^ acc ^ MSG0 ^ 64'(i >> 2));
            t = 0;
            while (!bus.o_out_valid && t < 100) begin
                @(negedge clk); t++;
            end
            chk("out_wait", 64'(t < 100), 1);
            if (i == 0 && v.stall > 0) begin
                hd = bus.o_out_data; ok = 1'b1; a1 = n_ack;
                for (int s = 0; s < v.stall; s++) begin
                    @(negedge clk);
                    ok &= bus.o_out_valid & (bus.o_out_data == hd) & (bus.o_out_last == (v.out_w == 1));
                end
                chk("stall_stable", ok, 1);
                chk("stall_no_ack", 64'(n_ack - a1), 0);
            end
            chk("out_data", bus.o_out_data, exp);
            chk("out_last", bus.o_out_last, i == v.out_w - 1);
            bus.i_out_ready = 1'b1;
            @(negedge clk);
            bus.i_out_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        cr_tog = 1'b0;
        chk("done_pulses", 64'(n_done - d0), 1);
        chk("ack_pulses", 64'(n_ack - a0), 64'(v.out_w - 1));
        chk("core_rst_cycles", 64'(n_rstn - r0), RC);
        chk("busy_after", bus.o_busy, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int r0, d0;
        vecs[0] = '{1, 4, 64'h1234567800000000, 64'h0, 64'h0, 0, 1'b0};
        vecs[1] = '{1, 2, 64'h1234567800000000, 64'h0, 64'h0, 0, 1'b0};
        vecs[2] = '{1, 2, 64'h0, 64'h0, 64'h0, 0, 1'b0};
        vecs[3] = '{1, 2, 64'hffffffffffffffff, 64'h0, 64'h0, 0, 1'b0};
        vecs[4] = '{3, 3, 64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f33cc55aa, 10, 1'b1};
        vecs[5] = '{2, 1, 64'hdeadbeefcafef00d, 64'h8000000000000001, 64'h0, 3, 1'b1};
        bus.i_cmd_valid = 1'b0; bus.i_cmd_in_words = '0; bus.i_cmd_out_words = '0;
        bus.i_msg_data = '0; bus.i_msg_valid = 1'b0; bus.i_out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.o_cmd_ready, 1);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_out_valid", bus.o_out_valid, 0);
        chk("rst_out_data", bus.o_out_data, 0);
        chk("rst_core_rst_n", bus.o_core_rst_n, 0);
        chk("rst_msg_ready", bus.o_msg_ready, 0);
        chk("rst_flags", {bus.o_done, bus.o_err, bus.o_core_ack, bus.o_core_valid, bus.o_out_last}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("core_rst_n_idle", bus.o_core_rst_n, 1);

        for (int j = 0; j < 6; j++) run_job(vecs[j]);

        r0 = n_rstn;
        send_cmd(0, 3);
        chk("err_pulse_in0", bus.o_err, 1);
        chk("err_cmd_ready", bus.o_cmd_ready, 1);
        chk("err_busy", bus.o_busy, 0);
        @(negedge clk);
        chk("err_clear", bus.o_err, 0);
        send_cmd(5, 0);
        chk("err_pulse_out0", bus.o_err, 1);
        @(negedge clk);
        chk("err_no_core_rst", 64'(n_rstn - r0), 0);

        d0 = n_done;
        send_cmd(3, 2);
        send_msg(64'h1111111111111111, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.o_busy, 0);
        chk("midrst_cmd_ready", bus.o_cmd_ready, 1);
        chk("midrst_core_rst_n", bus.o_core_rst_n, 0);
        chk("midrst_out_valid", bus.o_out_valid, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", 64'(n_done - d0), 0);
        run_job(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
